// File: rtl/csla_div_pkg.sv
// Shared types and constants for the carry-select sequential divider.
// FSM encoding plus the iteration-counter width helper.
package csla_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/csla_sub_stage.sv
// N-bit subtractor a - b built from 4-bit carry-select blocks; each block
// precomputes both borrow-in cases and the incoming borrow picks one.
module csla_sub_stage #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int NB = (N + 3) / 4;
  localparam int NP = NB * 4;

  logic [NP-1:0] a_p;
  logic [NP-1:0] b_p;
  logic [NP-1:0] d_p;
  logic [NB:0]   bc;

  assign a_p   = NP'(a);
  assign b_p   = NP'(b);
  assign bc[0] = 1'b0;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [4:0] r0;
    logic [4:0] r1;
    assign r0 = {1'b0, a_p[4*i +: 4]} - {1'b0, b_p[4*i +: 4]};
    assign r1 = {1'b0, a_p[4*i +: 4]} - {1'b0, b_p[4*i +: 4]} - 5'd1;
    assign d_p[4*i +: 4] = bc[i] ? r1[3:0] : r0[3:0];
    assign bc[i+1]       = bc[i] ? r1[4]   : r0[4];
  end

  // Zero padding only propagates the borrow, so the top block's borrow is exact.
  if (NP > N) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^d_p[NP-1:N];
  end

  assign diff   = d_p[N-1:0];
  assign borrow = bc[NB];

endmodule

// File: rtl/csla_seq_divider.sv
// Iterative restoring divider, one quotient bit per clock via csla_sub_stage.
// Optional macro CSLA_DIV_SIGNED_EN selects two's-complement operands.
module csla_seq_divider
  import csla_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   p_nxt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   t;
  logic             t_borrow;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             div0;
  logic             unused_p_msb;

  assign last = (cnt == '0);
  assign div0 = (divisor == '0);

`ifdef CSLA_DIV_SIGNED_EN
  localparam state_t RUN_EXIT = FIX;
  logic neg_q;
  logic neg_r;
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  localparam state_t RUN_EXIT = DONE;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // A restoring step always leaves P below the divisor, so P's msb stays zero.
  assign unused_p_msb = p[WIDTH];
  assign shifted      = {p[WIDTH-1:0], q[WIDTH-1]};

  csla_sub_stage #(.N(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (t),
    .borrow (t_borrow)
  );

  assign p_nxt = t_borrow ? shifted : t;
  assign q_nxt = {q[WIDTH-2:0], ~t_borrow};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div0 ? DONE : RUN;
      RUN:     if (last)  state_nxt = RUN_EXIT;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the datapath is reset too so an aborted run leaves no stale operands behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p           <= '0;
      q           <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef CSLA_DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (div0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              p   <= '0;
              q   <= dvd_mag;
              dvs <= dvs_mag;
              cnt <= CW'(WIDTH - 1);
`ifdef CSLA_DIV_SIGNED_EN
              neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r <= dividend[WIDTH-1];
`endif
            end
          end
        end
        RUN: begin
          p   <= p_nxt;
          q   <= q_nxt;
          cnt <= cnt - 1'b1;
`ifndef CSLA_DIV_SIGNED_EN
          if (last) begin
            quotient    <= q_nxt;
            remainder   <= p_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
`endif
        end
        FIX: begin
`ifdef CSLA_DIV_SIGNED_EN
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          quotient    <= neg_q ? -q : q;
          remainder   <= neg_r ? -p[WIDTH-1:0] : p[WIDTH-1:0];
          div_by_zero <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csla_seq_divider.sv
// Self-checking bench for csla_seq_divider (WIDTH=8): vector table plus
// hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_csla_seq_divider;

  localparam int W = 8;
`ifdef CSLA_DIV_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  vec_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_miss = 0;

  csla_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
    check({tag, "_quot"}, quotient, 0);
    check({tag, "_rem"}, remainder, 0);
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or reset applied).
  task automatic do_op(input string tag, input vec_t v, input int glitch_at,
                       input int reset_at, input bit b2b);
    vec_t e;
    int   cyc;
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    sb.push_back(v);
    if (b2b) begin
      @(negedge clk);
      check({tag, "_b2b_idle_done"}, done, 0);
    end
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({tag, "_busy_c1"}, busy, v.dbz ? 0 : 1);
    while (!done && cyc < 4 * W) begin
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_zero_outputs({tag, "_rst"});
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (cyc == glitch_at) begin
        start    = 1'b1;
        dividend = 8'd3;
        divisor  = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!done) begin
      check({tag, "_done_timeout"}, done, 1);
      return;
    end
    check({tag, "_latency"}, cyc, e.dbz ? 1 : LAT);
    check({tag, "_quot"}, quotient, e.q);
    check({tag, "_rem"}, remainder, e.r);
    check({tag, "_dbz"}, div_by_zero, e.dbz);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    vec_t v;
`ifdef CSLA_DIV_SIGNED_EN
    tbl.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0});  // -7/2
    tbl.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});  // -128/-1 wraps
    tbl.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0});  // 7/-2
    tbl.push_back('{8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0});  // -7/-2
    tbl.push_back('{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0});  // -100/7
    tbl.push_back('{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0});  // 127/-128
    tbl.push_back('{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1});  // 5/0
    tbl.push_back('{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1});  // -5/0
    tbl.push_back('{8'd100, 8'd9, 8'd11, 8'd1, 1'b0});
`else
    tbl.push_back('{8'd200, 8'd7,   8'd28,  8'd4,  1'b0});
    tbl.push_back('{8'd5,   8'd0,   8'hFF,  8'd5,  1'b1});
    tbl.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0});
    tbl.push_back('{8'd3,   8'd10,  8'd0,   8'd3,  1'b0});
    tbl.push_back('{8'd0,   8'd5,   8'd0,   8'd0,  1'b0});
    tbl.push_back('{8'd255, 8'd255, 8'd1,   8'd0,  1'b0});
    tbl.push_back('{8'd128, 8'd3,   8'd42,  8'd2,  1'b0});
    tbl.push_back('{8'd1,   8'd255, 8'd0,   8'd1,  1'b0});
    tbl.push_back('{8'd250, 8'd16,  8'd15,  8'd10, 1'b0});
`endif

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      do_op($sformatf("vec%0d", i), tbl[i], 0, 0, 1'b0);
      @(negedge clk);
    end

    // Start raised mid-run must be ignored and never queued.
    v = '{8'd100, 8'd9, 8'd11, 8'd1, 1'b0};
    do_op("ignored_start", v, 4, 0, 1'b0);
    @(negedge clk);
    check("ignored_start_no_queue_done", done, 0);
    check("ignored_start_no_queue_busy", busy, 0);
    check("ignored_start_hold_quot", quotient, 8'd11);
    check("ignored_start_hold_rem", remainder, 8'd1);

    // Back-to-back: second start raised in the done cycle.
    do_op("b2b_first", tbl[0], 0, 0, 1'b0);
    do_op("b2b_second", v, 0, 0, 1'b1);
    @(negedge clk);

    // Reset in cycle 3 of a run, then a fresh operation.
    v = '{8'd200, 8'd7, 8'd28, 8'd4, 1'b0};
    do_op("mid_reset", v, 0, 3, 1'b0);
    @(negedge clk);
    v = '{8'd50, 8'd5, 8'd10, 8'd0, 1'b0};
    do_op("after_reset", v, 0, 0, 1'b0);
    @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
